// File: rtl/csr_file.sv
// Machine-mode CSR file for a single-hart RISC-V core: CSR read/modify/write,
// 64-bit cycle/instret counters, and interrupt trap entry/exit bookkeeping.
module csr_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_req_valid,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_op,
  input  logic        csr_write,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        mret,
  input  logic        instr_retired,
  input  logic        irq_ext,
  input  logic        irq_timer,
  output logic        trap_valid,
  output logic [31:0] trap_vector,
  input  logic        trap_ack,
  input  logic [31:0] trap_epc,
  output logic [31:0] epc_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  logic        r_mie;
  logic        r_mpie;
  logic        r_mtie;
  logic        r_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  logic [1:0][63:0] w_cnt;
  logic [31:0]      w_mstatus;
  logic [31:0]      w_mie_val;
  logic [31:0]      w_mip;
  logic [31:0]      w_rvalue;
  logic [31:0]      w_new;
  logic             w_mapped;
  logic             w_ro;
  logic             w_op_ok;
  logic             w_commit;
  logic             w_trap_take;
  logic             w_mret_take;

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign w_mie_val = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
  assign w_mip     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};

  // Address decode and pre-write read value.
  always_comb begin
    w_rvalue = 32'b0;
    w_mapped = 1'b1;
    w_ro     = (csr_addr[11:10] == 2'b11);
    case (csr_addr)
      A_MSTATUS:              w_rvalue = w_mstatus;
      A_MIE:                  w_rvalue = w_mie_val;
      A_MTVEC:                w_rvalue = r_mtvec;
      A_MSCRATCH:             w_rvalue = r_mscratch;
      A_MEPC:                 w_rvalue = r_mepc;
      A_MCAUSE:               w_rvalue = r_mcause;
      A_MIP: begin
        w_rvalue = w_mip;
        w_ro     = 1'b1;
      end
      A_MCYCLE,   A_CYCLE:    w_rvalue = w_cnt[0][31:0];
      A_MCYCLEH,  A_CYCLEH:   w_rvalue = w_cnt[0][63:32];
      A_MINSTRET, A_INSTRET:  w_rvalue = w_cnt[1][31:0];
      A_MINSTRETH, A_INSTRETH: w_rvalue = w_cnt[1][63:32];
      A_MHARTID:              w_rvalue = 32'b0;
      default:                w_mapped = 1'b0;
    endcase
  end

  assign csr_illegal = csr_req_valid & (~w_mapped | (csr_write & w_ro));
  assign csr_rdata   = csr_illegal ? 32'b0 : w_rvalue;

  always_comb begin
    w_new   = csr_wdata;
    w_op_ok = 1'b1;
    case (csr_op)
      3'b001, 3'b101: w_new = csr_wdata;
      3'b010, 3'b110: w_new = w_rvalue | csr_wdata;
      3'b011, 3'b111: w_new = w_rvalue & ~csr_wdata;
      default: begin
        w_new   = w_rvalue;
        w_op_ok = 1'b0;
      end
    endcase
  end

  // Any trap_ack blocks a CSR write; only a genuine pending trap changes state.
  assign w_commit    = csr_req_valid & csr_write & ~csr_illegal & ~trap_ack & w_op_ok;
  assign trap_valid  = r_mie & ((r_meie & irq_ext) | (r_mtie & irq_timer));
  assign w_trap_take = trap_ack & trap_valid;
  assign w_mret_take = mret & ~w_trap_take;

  assign trap_vector = {r_mtvec[31:2], 2'b00};
  assign epc_out     = r_mepc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (w_trap_take) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else begin
      if (w_mret_take) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
      if (w_commit && csr_addr == A_MSTATUS) begin
        r_mie  <= w_new[3];
        r_mpie <= w_new[7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mepc   <= 32'b0;
      r_mcause <= 32'b0;
    end else if (w_trap_take) begin
      r_mepc   <= trap_epc & 32'hFFFF_FFFC;
      r_mcause <= (r_meie & irq_ext) ? CAUSE_EXT : CAUSE_TIMER;
    end else if (w_commit) begin
      if (csr_addr == A_MEPC)
        r_mepc <= w_new & 32'hFFFF_FFFC;
      if (csr_addr == A_MCAUSE)
        r_mcause <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtvec    <= 32'b0;
      r_mscratch <= 32'b0;
    end else if (w_commit) begin
      if (csr_addr == A_MIE) begin
        r_mtie <= w_new[7];
        r_meie <= w_new[11];
      end
      if (csr_addr == A_MTVEC)
        r_mtvec <= w_new & 32'hFFFF_FFFC;
      if (csr_addr == A_MSCRATCH)
        r_mscratch <= w_new;
    end
  end

  // Counter 0 is mcycle (always counts), counter 1 is minstret (counts retirements).
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam logic [11:0] LO_ADDR = (gi == 0) ? A_MCYCLE  : A_MINSTRET;
    localparam logic [11:0] HI_ADDR = (gi == 0) ? A_MCYCLEH : A_MINSTRETH;

    logic [63:0] r_cnt;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_inc;

    assign w_wr_lo = w_commit & (csr_addr == LO_ADDR);
    assign w_wr_hi = w_commit & (csr_addr == HI_ADDR);
    assign w_inc   = (gi == 0) ? 1'b1 : instr_retired;

    always_ff @(posedge clk) begin
      if (reset)
        r_cnt <= 64'b0;
      else if (w_wr_lo)
        r_cnt[31:0] <= w_new;
      else if (w_wr_hi)
        r_cnt[63:32] <= w_new;
      else if (w_inc)
        r_cnt <= r_cnt + 64'd1;
    end

    assign w_cnt[gi] = r_cnt;
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: an architectural model checked every cycle,
// plus hand-computed literal expectations at the key points.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_req_valid;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic        csr_write;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        mret;
  logic        instr_retired;
  logic        irq_ext;
  logic        irq_timer;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        trap_ack;
  logic [31:0] trap_epc;
  logic [31:0] epc_out;

  csr_file dut (
    .clk(clk), .reset(reset),
    .csr_req_valid(csr_req_valid), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_write(csr_write), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .mret(mret), .instr_retired(instr_retired),
    .irq_ext(irq_ext), .irq_timer(irq_timer),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .trap_ack(trap_ack), .trap_epc(trap_epc), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;

  // Architectural state of the model
  bit          m_mie, m_mpie, m_meie, m_mtie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  function automatic bit m_known(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                     12'hB00, 12'hB80, 12'hB02, 12'hB82,
                     12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14};
  endfunction

  function automatic logic [31:0] m_value(input logic [11:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h304: v = (m_meie ? 32'h800 : 32'h0) + (m_mtie ? 32'h80 : 32'h0);
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: v = (irq_ext ? 32'h800 : 32'h0) + (irq_timer ? 32'h80 : 32'h0);
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic bit m_illegal();
    bit ro;
    ro = (csr_addr >= 12'hC00) || (csr_addr == 12'h344);
    return csr_req_valid && (!m_known(csr_addr) || (csr_write && ro));
  endfunction

  function automatic bit m_trap_valid();
    return m_mie && ((m_meie && irq_ext) || (m_mtie && irq_timer));
  endfunction

  task automatic model_step();
    logic [31:0] old, nv;
    logic [63:0] cyc_n, ins_n;
    bit commit;
    if (reset) begin
      {m_mie, m_mpie, m_meie, m_mtie} = 4'b0;
      m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_cyc = 0; m_ins = 0;
      return;
    end
    old = m_value(csr_addr);
    case (csr_op)
      3'd1, 3'd5: nv = csr_wdata;
      3'd2, 3'd6: nv = old | csr_wdata;
      3'd3, 3'd7: nv = old & ~csr_wdata;
      default:    nv = old;
    endcase
    commit = csr_req_valid && csr_write && !m_illegal() && !trap_ack &&
             (csr_op inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7});
    cyc_n = m_cyc + 1;
    ins_n = instr_retired ? m_ins + 1 : m_ins;
    if (trap_ack && m_trap_valid()) begin
      m_mepc   = trap_epc & ~32'h3;
      m_mcause = (m_meie && irq_ext) ? 32'h8000_000B : 32'h8000_0007;
      m_mpie   = m_mie;
      m_mie    = 1'b0;
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
    end
    if (commit) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: begin m_mtie = nv[7]; m_meie = nv[11]; end
        12'h305: m_mtvec = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'hB00: cyc_n = {m_cyc[63:32], nv};
        12'hB80: cyc_n = {nv, m_cyc[31:0]};
        12'hB02: ins_n = {m_ins[63:32], nv};
        12'hB82: ins_n = {nv, m_ins[31:0]};
        default: ;
      endcase
    end
    m_cyc = cyc_n;
    m_ins = ins_n;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cyc_illegal", {31'b0, csr_illegal}, {31'b0, m_illegal()});
      chk("cyc_rdata", csr_rdata, m_illegal() ? 32'h0 : m_value(csr_addr));
      chk("cyc_trap_valid", {31'b0, trap_valid}, {31'b0, m_trap_valid()});
      chk("cyc_trap_vector", trap_vector, m_mtvec);
      chk("cyc_epc_out", epc_out, m_mepc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_req_valid = 0; csr_addr = 0; csr_op = 0; csr_write = 0; csr_wdata = 0;
    mret = 0; instr_retired = 0; trap_ack = 0; trap_epc = 0;
  endtask

  task automatic put(input logic [11:0] a, input logic [2:0] op, input logic w,
                     input logic [31:0] d);
    csr_req_valid = 1; csr_addr = a; csr_op = op; csr_write = w; csr_wdata = d;
    #1;
    $display("[TB] csr addr=%h op=%0d wr=%0d wdata=%h -> rdata=%h illegal=%0d",
             a, op, w, d, csr_rdata, csr_illegal);
  endtask

  initial begin
    idle();
    reset = 1; irq_ext = 0; irq_timer = 0;
    tick(); tick();
    cmp_en = 1;
    chk("rst_trap_valid", {31'b0, trap_valid}, 32'h0);
    chk("rst_epc_out", epc_out, 32'h0);
    reset = 0;

    // Counter start value after reset, then read-only alias read
    put(12'hC00, RS, 0, 0);
    chk("cycle_first", csr_rdata, 32'h0);
    chk("cycle_alias_legal", {31'b0, csr_illegal}, 32'h0);
    tick(); idle();
    put(12'hB00, RS, 0, 0);
    chk("cycle_second", csr_rdata, 32'h1);
    tick(); idle();
    put(12'h300, RS, 0, 0);
    chk("mstatus_reset", csr_rdata, 32'h1800);
    tick(); idle();

    // mtvec write/modify
    put(12'h305, RW, 1, 32'h8000_0103);
    chk("mtvec_rw_old", csr_rdata, 32'h0);
    tick(); idle();
    put(12'h305, RS, 0, 0);
    chk("mtvec_read", csr_rdata, 32'h8000_0100);
    chk("trap_vector", trap_vector, 32'h8000_0100);
    tick(); idle();
    put(12'h305, RC, 1, 32'h100);
    tick(); idle();
    put(12'h305, RS, 0, 0);
    chk("mtvec_rc", csr_rdata, 32'h8000_0000);
    tick(); idle();

    // Illegal accesses
    put(12'hC00, RW, 1, 32'h1234);
    chk("ro_write_illegal", {31'b0, csr_illegal}, 32'h1);
    chk("ro_write_rdata", csr_rdata, 32'h0);
    tick(); idle();
    put(12'h7FF, RW, 1, 32'h55);
    chk("unmapped_illegal", {31'b0, csr_illegal}, 32'h1);
    chk("unmapped_rdata", csr_rdata, 32'h0);
    tick(); idle();
    csr_addr = 12'h7FF; csr_write = 1; csr_op = RW; #1;
    chk("no_valid_no_illegal", {31'b0, csr_illegal}, 32'h0);
    tick(); idle();
    put(12'hF14, RS, 0, 0);
    chk("mhartid", csr_rdata, 32'h0);
    tick(); idle();
    irq_ext = 1; irq_timer = 1;
    put(12'h344, RS, 0, 0);
    chk("mip_read", csr_rdata, 32'h880);
    tick(); idle();
    put(12'h344, RW, 1, 0);
    chk("mip_write_illegal", {31'b0, csr_illegal}, 32'h1);
    tick(); idle();

    // Trap entry with external interrupt
    put(12'h304, RW, 1, 32'h880);
    tick(); idle();
    put(12'h300, RS, 1, 32'h8);
    tick(); idle(); #1;
    chk("trap_valid_set", {31'b0, trap_valid}, 32'h1);
    trap_ack = 1; trap_epc = 32'h1006;
    tick(); idle();
    put(12'h342, RS, 0, 0);
    chk("trap_valid_after_ack", {31'b0, trap_valid}, 32'h0);
    chk("mepc_after_trap", epc_out, 32'h1004);
    chk("mcause_ext", csr_rdata, 32'h8000_000B);
    tick(); idle();
    put(12'h300, RS, 0, 0);
    chk("mstatus_in_trap", csr_rdata, 32'h1880);
    mret = 1;
    tick(); idle();
    put(12'h300, RS, 0, 0);
    chk("mstatus_after_mret", csr_rdata, 32'h1888);
    chk("trap_valid_again", {31'b0, trap_valid}, 32'h1);
    tick(); idle();

    // Timer cause when external is pending but not enabled
    put(12'h304, RW, 1, 32'h80);
    tick(); idle();
    trap_ack = 1; trap_epc = 32'h2003;
    tick(); idle();
    put(12'h342, RS, 0, 0);
    chk("mcause_timer", csr_rdata, 32'h8000_0007);
    chk("mepc_timer", epc_out, 32'h2000);
    tick(); idle();
    trap_ack = 1; trap_epc = 32'h5555; #1;
    chk("noop_ack_trap_valid", {31'b0, trap_valid}, 32'h0);
    tick(); idle(); #1;
    chk("noop_ack_mepc", epc_out, 32'h2000);
    irq_ext = 0;
    mret = 1;
    tick(); idle();

    // Counter wrap
    put(12'hB80, RW, 1, 32'hFFFF_FFFF);
    tick(); idle();
    put(12'hB00, RW, 1, 32'hFFFF_FFFF);
    tick(); idle();
    put(12'hB00, RS, 0, 0);
    chk("mcycle_written", csr_rdata, 32'hFFFF_FFFF);
    tick(); idle();
    put(12'hB80, RS, 0, 0);
    chk("mcycleh_wrapped", csr_rdata, 32'h0);
    tick(); idle();
    put(12'hB00, RS, 0, 0);
    chk("mcycle_after_wrap", csr_rdata, 32'h1);
    tick(); idle();

    // minstret write suppresses the same-cycle increment
    put(12'hB02, RW, 1, 32'h5);
    instr_retired = 1;
    tick(); idle();
    put(12'hB02, RS, 0, 0);
    chk("minstret_written", csr_rdata, 32'h5);
    tick(); idle();
    put(12'hB02, RS, 0, 0);
    chk("minstret_hold", csr_rdata, 32'h5);
    instr_retired = 1;
    tick(); idle();
    put(12'hC02, RS, 0, 0);
    chk("minstret_inc", csr_rdata, 32'h6);
    tick(); idle();

    // trap_ack + mret + CSR write in one cycle
    put(12'h340, RW, 1, 32'h1234);
    tick(); idle();
    trap_ack = 1; trap_epc = 32'h3008; mret = 1;
    put(12'h340, RW, 1, 32'hDEAD);
    chk("combo_trap_valid", {31'b0, trap_valid}, 32'h1);
    tick(); idle();
    put(12'h340, RS, 0, 0);
    chk("combo_mscratch", csr_rdata, 32'h1234);
    chk("combo_mepc", epc_out, 32'h3008);
    tick(); idle();
    put(12'h300, RS, 0, 0);
    chk("combo_mstatus", csr_rdata, 32'h1880);
    mret = 1;
    tick(); idle();

    // Same stimulus under reset
    reset = 1;
    trap_ack = 1; trap_epc = 32'h3008; mret = 1;
    put(12'h340, RW, 1, 32'hDEAD);
    tick(); idle();
    reset = 0;
    put(12'h340, RS, 0, 0);
    chk("rst_mscratch", csr_rdata, 32'h0);
    chk("rst2_epc_out", epc_out, 32'h0);
    chk("rst2_trap_valid", {31'b0, trap_valid}, 32'h0);
    tick(); idle();
    put(12'h300, RS, 0, 0);
    chk("rst2_mstatus", csr_rdata, 32'h1800);
    tick(); idle();
    irq_timer = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: reset  input  1  reset is synchronous and active-high.
REQ-003 SHALL: csr_req_valid  input  1  CSR instruction present at the MEM stage this cycle.
REQ-004 SHALL: csr_addr  input  12  CSR address.
REQ-005 SHALL: csr_op  input  3  fun3 encoding: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-006 SHALL: csr_write  input  1  write intent; 0 for RS/RC/RSI/RCI whose source is zero.
REQ-007 SHALL: csr_wdata  input  32  rs1 value, or zero-extended 5-bit immediate for the I-forms.
REQ-008 SHALL: csr_rdata  output  32  combinational pre-write value of the addressed CSR; 0 when illegal.
REQ-009 SHALL: csr_illegal  output  1  combinational flag: unmapped address, or write intent to a read-only CSR.
REQ-010 SHALL: mret  input  1  MRET instruction retiring this cycle.
REQ-011 SHALL: instr_retired  input  1  one instruction retired this cycle.
REQ-012 SHALL: irq_ext, irq_timer  input  1 each  level-sensitive interrupt lines.
REQ-013 SHALL: trap_valid  output  1  interrupt pending, enabled and globally enabled.
REQ-014 SHALL: trap_vector  output  32  mtvec with bits[1:0] forced to 0.
REQ-015 SHALL: trap_ack  input  1  pipeline takes the trap this cycle.
REQ-016 SHALL: trap_epc  input  32  PC saved on trap_ack.
REQ-017 SHALL: epc_out  output  32  current mepc; the MRET target.

Function
REQ-018 SHALL: implement the following CSR map:
- mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] read as 11; all other bits read 0.
- mie 0x304: MTIE bit7, MEIE bit11.
- mtvec 0x305: bits[1:0] read 0 (direct mode).
- mscratch 0x340: 32 bits.
- mepc 0x341: bits[1:0] read 0.
- mcause 0x342: 32 bits.
- mip 0x344 (read-only): MTIP bit7 = irq_timer, MEIP bit11 = irq_ext.
- mcycle/mcycleh 0xB00/0xB80.
- minstret/minstreth 0xB02/0xB82.
- read-only aliases 0xC00/0xC80/0xC02/0xC82.
- mhartid 0xF14 (read-only) = 0.
REQ-019 SHALL: compute the new value from old = csr_rdata: RW/RWI -> wdata; RS/RSI -> old | wdata; RC/RCI -> old & ~wdata.
REQ-020 SHALL: commit a write at the next edge only when csr_req_valid & csr_write & ~csr_illegal & ~trap_ack.
REQ-021 SHALL: treat csr_addr[11:10]==11 as read-only; write intent there raises csr_illegal and changes no state.
REQ-022 SHALL: keep csr_illegal=0 whenever csr_req_valid=0.
REQ-023 SHALL: increment the 64-bit mcycle every cycle outside reset; wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-024 SHALL: increment the 64-bit minstret when instr_retired=1, with the same wrap.
REQ-025 SHALL: for a CSR write to a counter half, let the written half take the written value with no increment that cycle; the other half holds.
REQ-026 SHALL: drive trap_valid = mstatus.MIE & ((mie.MEIE & irq_ext) | (mie.MTIE & irq_timer)), combinationally.
REQ-027 SHALL: on trap_ack, set mepc <= trap_epc & ~3, MPIE <= MIE, MIE <= 0; mcause <= 0x8000_000B if the external interrupt is enabled and pending, else 0x8000_0007.
REQ-028 SHALL: on mret (without trap_ack), set MIE <= MPIE and MPIE <= 1.
REQ-029 SHALL: give trap_ack priority over simultaneous mret and over any CSR write.
REQ-030 SHALL: treat trap_ack while trap_valid=0 as a no-op.
REQ-031 SHALL: deassert trap_valid in the cycle after trap_ack, because MIE is cleared.

Reset
REQ-032 SHALL: on reset=1 at an edge, clear all CSRs and counters to 0, set MPP=11 and MPIE=0, and ignore all other inputs.
REQ-033 SHALL: drive trap_valid=0 and epc_out=0 after reset; csr_rdata/csr_illegal reflect the reset state combinationally.
REQ-034 SHALL: let reset asserted mid-trap or mid-write win over trap_ack, mret and writes in the same cycle.

Verification
REQ-035 SHALL: cover CSRRW 0x305 wdata 0x8000_0103 -> csr_rdata 0, then mtvec reads 0x8000_0100; CSRRC 0x305 wdata 0x100 -> 0x8000_0000.
REQ-036 SHALL: cover CSRRW 0xC00 or csr_addr 0x7FF with write intent -> csr_illegal=1, rdata 0, no state change; CSRRS 0xC00 with csr_write=0 -> legal, reads the cycle count.
REQ-037 SHALL: cover mie=0x880, MIE=1, irq_ext=irq_timer=1 -> trap_valid=1; trap_ack, trap_epc 0x1006 -> mepc 0x1004, mcause 0x8000_000B, MIE 0, MPIE 1, trap_valid 0 next cycle; then mret -> MIE 1.
REQ-038 SHALL: cover mcycle write 0xFFFF_FFFF to 0xB00 with mcycleh 0xFFFF_FFFF -> the following cycle wraps both halves to 0.
REQ-039 SHALL: cover trap_ack, mret and a CSRRW to mscratch in the same cycle -> trap update only, mscratch unchanged; reset with the same stimulus -> all zero.
